// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control types: the scoreboard entry record and result latency classes.
// Entry fields are sized for the widest supported configuration; narrower ports zero-extend.
package pipe_ctrl_pkg;

  localparam int SB_DST_MAX_W = 8;
  localparam int SB_LAT_MAX_W = 4;

  localparam int LAT_ALU  = 0;
  localparam int LAT_LOAD = 1;

  typedef struct packed {
    logic                    valid;
    logic                    regw;
    logic [SB_DST_MAX_W-1:0] dst;
    logic [SB_LAT_MAX_W-1:0] lat;
  } sb_entry_t;

endpackage

// File: rtl/pipe_scoreboard_sb_match.sv
// Matches one source operand against the scoreboard entries and reports hazard / forward select.
// The youngest matching writer (smallest stage index) decides the outcome.
module sb_match
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int REG_ADDR_W = 5,
  parameter bit ZERO_REG   = 1'b0,
  localparam int SEL_W     = $clog2(NUM_STAGES)
) (
  input  sb_entry_t             i_entries [NUM_STAGES],
  input  logic [REG_ADDR_W-1:0] i_src,
  input  logic                  i_use,
  output logic                  o_hazard,
  output logic [SEL_W-1:0]      o_sel
);

  logic [SB_DST_MAX_W-1:0] w_srcExt;
  logic                    w_blocked;
  logic                    w_found;
  int                      w_idx;
  int                      w_lat;

  assign w_srcExt  = SB_DST_MAX_W'(i_src);
  assign w_blocked = ZERO_REG && (i_src == '0);

  // Scan oldest to youngest so the youngest matching writer overrides older ones.
  always_comb begin
    w_found  = 1'b0;
    w_idx    = 0;
    w_lat    = 0;
    o_hazard = 1'b0;
    o_sel    = '0;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      if (i_entries[k].valid && i_entries[k].regw && (i_entries[k].dst == w_srcExt)) begin
        w_found = 1'b1;
        w_idx   = k;
        w_lat   = int'(i_entries[k].lat);
      end
    end
    if (i_use && w_found && !w_blocked) begin
      if (w_idx < w_lat) begin
        o_hazard = 1'b1;
      end else if (w_idx + 1 < NUM_STAGES) begin
        o_sel = SEL_W'(w_idx + 1);
      end
    end
  end

endmodule

// File: rtl/pipe_scoreboard.sv
// Shift-register scoreboard beside decode: decides stall/issue for the ID instruction and
// registers per-operand forward selects for EX. Supports REG_ADDR_W <= 8 and LAT_W <= 4.
module pipe_scoreboard
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int REG_ADDR_W = 5,
  parameter int LAT_W      = 2,
  parameter bit ZERO_REG   = 1'b0,
  localparam int SEL_W     = $clog2(NUM_STAGES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_src1_i,
  input  logic [REG_ADDR_W-1:0] id_src2_i,
  input  logic                  id_src1_use_i,
  input  logic                  id_src2_use_i,
  input  logic [REG_ADDR_W-1:0] id_dst_i,
  input  logic                  id_regw_i,
  input  logic [LAT_W-1:0]      id_lat_i,
  input  logic                  hold_i,
  input  logic                  flush_i,
  output logic                  stall_o,
  output logic                  issue_o,
  output logic [SEL_W-1:0]      fwd1_sel_o,
  output logic [SEL_W-1:0]      fwd2_sel_o,
  output logic                  busy_o
);

  sb_entry_t        r_entries [NUM_STAGES];
  logic [SEL_W-1:0] r_fwd1Sel;
  logic [SEL_W-1:0] r_fwd2Sel;

  logic             w_haz1;
  logic             w_haz2;
  logic [SEL_W-1:0] w_sel1;
  logic [SEL_W-1:0] w_sel2;

  sb_match #(
    .NUM_STAGES(NUM_STAGES),
    .REG_ADDR_W(REG_ADDR_W),
    .ZERO_REG  (ZERO_REG)
  ) u_match1 (
    .i_entries(r_entries),
    .i_src    (id_src1_i),
    .i_use    (id_src1_use_i),
    .o_hazard (w_haz1),
    .o_sel    (w_sel1)
  );

  sb_match #(
    .NUM_STAGES(NUM_STAGES),
    .REG_ADDR_W(REG_ADDR_W),
    .ZERO_REG  (ZERO_REG)
  ) u_match2 (
    .i_entries(r_entries),
    .i_src    (id_src2_i),
    .i_use    (id_src2_use_i),
    .o_hazard (w_haz2),
    .o_sel    (w_sel2)
  );

  assign stall_o = id_valid_i & (w_haz1 | w_haz2);
  assign issue_o = id_valid_i & ~stall_o & ~flush_i & ~hold_i;

  // A non-issuing cycle injects a bubble; hold freezes entries and selects together.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        r_entries[k] <= '0;
      end
      r_fwd1Sel <= '0;
      r_fwd2Sel <= '0;
    end else if (!hold_i) begin
      for (int k = 1; k < NUM_STAGES; k++) begin
        r_entries[k] <= r_entries[k-1];
      end
      if (issue_o) begin
        r_entries[0].valid <= 1'b1;
        r_entries[0].regw  <= id_regw_i;
        r_entries[0].dst   <= SB_DST_MAX_W'(id_dst_i);
        r_entries[0].lat   <= SB_LAT_MAX_W'(id_lat_i);
        r_fwd1Sel          <= w_sel1;
        r_fwd2Sel          <= w_sel2;
      end else begin
        r_entries[0] <= '0;
        r_fwd1Sel    <= '0;
        r_fwd2Sel    <= '0;
      end
    end
  end

  always_comb begin
    busy_o = 1'b0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      busy_o = busy_o | r_entries[k].valid;
    end
  end

  assign fwd1_sel_o = r_fwd1Sel;
  assign fwd2_sel_o = r_fwd2Sel;

  // A writer whose result appears only in WB or later cannot be forwarded in time.
  a_latLegal : assert property (@(posedge clk) disable iff (rst)
    (id_valid_i && id_regw_i) |-> (int'(id_lat_i) < NUM_STAGES - 1));

endmodule

// File: doc/pipe_scoreboard.md
# pipe_scoreboard

Parametrised hazard-detection and forwarding-select unit for the in-order integer pipeline. It replaces the fixed EX/MEM/WB hazard and forward logic with a shift-register scoreboard of NUM_STAGES post-decode entries. Each entry carries a per-instruction result latency, so multi-cycle producers stall exactly as long as required. It sits beside decode: it observes the instruction in ID, decides stall and issue, and registers per-operand forward selects for use in EX.

## Interface
- NUM_STAGES, 3, tracked post-decode stages (entry 0 = EX, last = WB); legal range ≥ 2
- REG_ADDR_W, 5, register-address width
- LAT_W, 2, width of latency class
- ZERO_REG, 0, if 1, register 0 never matches (no hazard, no forward)
- SEL_W (localparam), $clog2(NUM_STAGES), forward-select width
- clk  in  1  clock; one clock domain
- rst  in  1  reset, synchronous, active-high
- id_valid_i  in  1  valid instruction in ID
- id_src1_i / id_src2_i  in  REG_ADDR_W  source registers
- id_src1_use_i / id_src2_use_i  in  1  source actually read
- id_dst_i  in  REG_ADDR_W  destination register
- id_regw_i  in  1  instruction writes a register
- id_lat_i  in  LAT_W  index of the stage at whose end the result exists (ALU 0, load 1)
- hold_i  in  1  back-end freeze (memory wait); all entries hold
- flush_i  in  1  squash ID this cycle (redirect)
- stall_o  out  1  ID must recirculate
- issue_o  out  1  ID instruction enters EX at next edge
- fwd1_sel_o / fwd2_sel_o  out  SEL_W  registered; valid for the instruction in EX; 0 = regfile/ID value, k = result register following stage k-1
- busy_o  out  1  any entry valid (halt drain)

## Operation
- Entry fields: valid, regw, dst, lat.
- Per used source s, match = youngest k (smallest index) with valid & regw & dst==s. No match when ZERO_REG=1 and s==0.
- Match at k with k ≥ lat: ready. sel = k+1 if k+1 < NUM_STAGES, else 0 (WB writes the regfile this cycle; the regfile write-before-read covers it).
- Match at k with k < lat: hazard.
- stall_o = id_valid_i & (hazard on src1 | hazard on src2). Unused sources never stall.
- issue_o = id_valid_i & ~stall_o & ~flush_i & ~hold_i.
- Advance when ~hold_i: entry[k+1] ← entry[k]; entry[NUM_STAGES-1] retires.
  - entry[0] ← {1, id_regw_i, id_dst_i, id_lat_i} if issue_o, else bubble (valid=0).
  - fwd sel registers ← computed sels if issue_o, else 0.
- hold_i=1: entries and fwd sel registers frozen. issue_o=0. stall_o still reflects hazards.
- Priority: rst > hold_i > flush_i > stall.
- Illegal: id_lat_i ≥ NUM_STAGES-1 with id_regw_i. Simulation assertion only.

## Timing
- Reset (sync, rst=1 at edge): all entries invalid, fwd sels 0. This yields stall_o=0, busy_o=0, issue_o=id_valid_i&~flush_i&~hold_i. Reset mid-operation discards all in-flight tracking.
- stall_o and issue_o are combinational from ID inputs and entry state, same cycle.
- fwd sels are registered; 1-cycle latency, aligned with the ID/EX register.
- Load-use (lat 1) back-to-back: exactly 1 stall cycle. ALU→ALU: 0 stalls, sel=1.
- Latency L producer followed immediately by a consumer: L stall cycles.
- Stall and hold together: hold governs; on release, the hazard is re-evaluated.

## Structure
- Shared package pipe_ctrl_pkg: sb_entry_t struct (valid, regw, dst, lat), LAT_ALU=0, LAT_LOAD=1 constants.
- Sub-module sb_match: one source operand against the entry array; outputs hazard and sel. Instantiated twice.
- The top holds the entry shift register, the sel registers, and the issue/stall logic.

## Test plan
- ALU r3 then ALU reading r3 (NUM_STAGES=3) -> stall_o=0; next cycle fwd1_sel_o=1.
- Load r5, lat 1, then consumer of r5 on src2 -> stall_o=1 for 1 cycle; after issue, fwd2_sel_o=2.
- Producer r7 two instructions ahead (entry 1 at ID time) -> sel 2. Three ahead (entry 2, WB) -> sel 0, no stall.
- Two in-flight writers of r4 at entries 0 and 1 -> youngest chosen, sel=1. ZERO_REG=1 with src=0 -> sel 0, no stall.
- hold_i=1 for 4 cycles with a pending load hazard -> entries frozen, issue_o=0, sels unchanged. After release, stall resolves on the same cycle count.
- flush_i with a valid ID -> issue_o=0, bubble enters EX, sels 0. rst mid-stream -> busy_o=0 at the next cycle.
